// File: rtl/corelet_ctrl.sv
// Tile sequencer upstream of the corelet: weight fetch/load, activation fetch/execute,
// then OFIFO drain through the SFP into PMEM. All outputs are registered.
module corelet_ctrl #(
    parameter int unsigned ROW      = 8,
    parameter int unsigned COL      = 8,
    parameter int unsigned XMEM_AW  = 11,
    parameter int unsigned PMEM_AW  = 11,
    parameter int unsigned LEN_BW   = 8,
    parameter int unsigned L0_DEPTH = 64,
    parameter int unsigned SFP_LAT  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_start,
    input  logic               i_acc,
    input  logic [XMEM_AW-1:0] i_w_base,
    input  logic [XMEM_AW-1:0] i_x_base,
    input  logic [PMEM_AW-1:0] i_p_base,
    input  logic [LEN_BW-1:0]  i_len,
    input  logic               i_ofifo_valid,
    output logic [1:0]         o_inst_w,
    output logic               o_l0_wr,
    output logic               o_l0_rd,
    output logic               o_xmem_cen,
    output logic [XMEM_AW-1:0] o_xmem_addr,
    output logic               o_ofifo_rd,
    output logic               o_sfp_acc_en,
    output logic               o_pmem_ren,
    output logic [PMEM_AW-1:0] o_pmem_raddr,
    output logic               o_pmem_wen,
    output logic [PMEM_AW-1:0] o_pmem_waddr,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err
);

    localparam int unsigned CNT_W = LEN_BW + 1;

    localparam logic [1:0] INST_IDLE = 2'b00;
    localparam logic [1:0] INST_LOAD = 2'b01;
    localparam logic [1:0] INST_EXEC = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        W_FETCH,
        W_LOAD,
        W_SETTLE,
        X_FETCH,
        X_EXEC,
        DRAIN,
        DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   idx;
    logic [CNT_W-1:0]   pop_cnt;
    logic [CNT_W-1:0]   wr_cnt;
    logic [CNT_W-1:0]   len;
    logic [XMEM_AW-1:0] w_base;
    logic [XMEM_AW-1:0] x_base;
    logic [PMEM_AW-1:0] p_base;
    logic               acc;
    logic [SFP_LAT-1:0] sfp_pipe;

    logic [CNT_W-1:0]   idx_inc;
    logic               last_col;
    logic               last_settle;
    logic               last_len;
    logic               pop_ok;
    logic               too_long;

    // Phase-end and pop-eligibility decodes feeding the registered sequencer.
    assign idx_inc     = idx + CNT_W'(1);
    assign last_col    = (idx == CNT_W'(COL - 1));
    assign last_settle = (idx == CNT_W'(ROW + COL - 1));
    assign last_len    = (idx == len - CNT_W'(1));
    assign pop_ok      = i_ofifo_valid && (pop_cnt < len);
    assign too_long    = CNT_W'(i_len) > CNT_W'(L0_DEPTH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            idx          <= '0;
            pop_cnt      <= '0;
            wr_cnt       <= '0;
            len          <= '0;
            w_base       <= '0;
            x_base       <= '0;
            p_base       <= '0;
            acc          <= 1'b0;
            sfp_pipe     <= '0;
            o_inst_w     <= INST_IDLE;
            o_l0_wr      <= 1'b0;
            o_l0_rd      <= 1'b0;
            o_xmem_cen   <= 1'b1;
            o_xmem_addr  <= '0;
            o_ofifo_rd   <= 1'b0;
            o_sfp_acc_en <= 1'b0;
            o_pmem_ren   <= 1'b0;
            o_pmem_raddr <= '0;
            o_pmem_wen   <= 1'b0;
            o_pmem_waddr <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            // L0 write trails each XMEM read by its one-cycle read latency.
            o_l0_wr      <= ~o_xmem_cen;
            o_ofifo_rd   <= 1'b0;
            o_pmem_ren   <= 1'b0;
            o_sfp_acc_en <= o_ofifo_rd & acc;
            o_pmem_wen   <= sfp_pipe[SFP_LAT-1];
            o_done       <= 1'b0;
            o_err        <= 1'b0;

            // Pop history delayed to the cycle SFP output is valid; writes land one later.
            sfp_pipe[0] <= o_ofifo_rd;
            for (int i = 1; i < SFP_LAT; i++) begin
                sfp_pipe[i] <= sfp_pipe[i-1];
            end
            if (sfp_pipe[SFP_LAT-1]) begin
                o_pmem_waddr <= p_base + PMEM_AW'(wr_cnt);
                wr_cnt       <= wr_cnt + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (i_start) begin
                        if (too_long) begin
                            o_err <= 1'b1;
                        end else begin
                            state       <= W_FETCH;
                            w_base      <= i_w_base;
                            x_base      <= i_x_base;
                            p_base      <= i_p_base;
                            len         <= CNT_W'(i_len);
                            acc         <= i_acc;
                            idx         <= '0;
                            pop_cnt     <= '0;
                            wr_cnt      <= '0;
                            o_busy      <= 1'b1;
                            o_xmem_cen  <= 1'b0;
                            o_xmem_addr <= i_w_base;
                        end
                    end
                end
                W_FETCH: begin
                    if (last_col) begin
                        state      <= W_LOAD;
                        idx        <= '0;
                        o_xmem_cen <= 1'b1;
                        o_l0_rd    <= 1'b1;
                        o_inst_w   <= INST_LOAD;
                    end else begin
                        idx         <= idx_inc;
                        o_xmem_addr <= w_base + XMEM_AW'(idx_inc);
                    end
                end
                W_LOAD: begin
                    if (last_col) begin
                        state    <= W_SETTLE;
                        idx      <= '0;
                        o_l0_rd  <= 1'b0;
                        o_inst_w <= INST_IDLE;
                    end else begin
                        idx <= idx_inc;
                    end
                end
                W_SETTLE: begin
                    if (last_settle) begin
                        idx <= '0;
                        if (len == '0) begin
                            state  <= DONE;
                            o_done <= 1'b1;
                        end else begin
                            state       <= X_FETCH;
                            o_xmem_cen  <= 1'b0;
                            o_xmem_addr <= x_base;
                        end
                    end else begin
                        idx <= idx_inc;
                    end
                end
                X_FETCH: begin
                    if (last_len) begin
                        state      <= X_EXEC;
                        idx        <= '0;
                        o_xmem_cen <= 1'b1;
                        o_l0_rd    <= 1'b1;
                        o_inst_w   <= INST_EXEC;
                    end else begin
                        idx         <= idx_inc;
                        o_xmem_addr <= x_base + XMEM_AW'(idx_inc);
                    end
                end
                X_EXEC: begin
                    if (last_len) begin
                        state    <= DRAIN;
                        idx      <= '0;
                        o_l0_rd  <= 1'b0;
                        o_inst_w <= INST_IDLE;
                    end else begin
                        idx <= idx_inc;
                    end
                end
                DRAIN: begin
                    if (pop_ok) begin
                        o_ofifo_rd   <= 1'b1;
                        o_pmem_ren   <= acc;
                        o_pmem_raddr <= p_base + PMEM_AW'(pop_cnt);
                        pop_cnt      <= pop_cnt + CNT_W'(1);
                    end
                    if (wr_cnt == len) begin
                        state  <= DONE;
                        o_done <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_corelet_ctrl.sv
// Self-checking bench for corelet_ctrl: directed tiles plus randomized tiles, checked
// against an event-level model of the expected address/strobe traces.
module tb_corelet_ctrl;

    localparam int ROW = 8;
    localparam int COL = 8;
    localparam int AW  = 11;
    localparam int LAT = 1;
    localparam int AMASK = (1 << AW) - 1;
    localparam logic [44:0] RST_OUTS = 45'h1 << 40;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          i_start = 1'b0;
    logic          i_acc = 1'b0;
    logic [AW-1:0] i_w_base = '0;
    logic [AW-1:0] i_x_base = '0;
    logic [AW-1:0] i_p_base = '0;
    logic [7:0]    i_len = '0;
    logic          i_ofifo_valid = 1'b0;
    logic [1:0]    o_inst_w;
    logic          o_l0_wr, o_l0_rd, o_xmem_cen, o_ofifo_rd, o_sfp_acc_en;
    logic          o_pmem_ren, o_pmem_wen, o_busy, o_done, o_err;
    logic [AW-1:0] o_xmem_addr, o_pmem_raddr, o_pmem_waddr;
    logic [44:0]   outs;

    corelet_ctrl dut (
        .clk(clk), .reset(reset), .i_start(i_start), .i_acc(i_acc),
        .i_w_base(i_w_base), .i_x_base(i_x_base), .i_p_base(i_p_base), .i_len(i_len),
        .i_ofifo_valid(i_ofifo_valid), .o_inst_w(o_inst_w), .o_l0_wr(o_l0_wr),
        .o_l0_rd(o_l0_rd), .o_xmem_cen(o_xmem_cen), .o_xmem_addr(o_xmem_addr),
        .o_ofifo_rd(o_ofifo_rd), .o_sfp_acc_en(o_sfp_acc_en), .o_pmem_ren(o_pmem_ren),
        .o_pmem_raddr(o_pmem_raddr), .o_pmem_wen(o_pmem_wen), .o_pmem_waddr(o_pmem_waddr),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    assign outs = {o_inst_w, o_l0_wr, o_l0_rd, o_xmem_cen, o_xmem_addr, o_ofifo_rd,
                   o_sfp_acc_en, o_pmem_ren, o_pmem_raddr, o_pmem_wen, o_pmem_waddr,
                   o_busy, o_done, o_err};

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint obs, input longint want);
        n_cmp++;
        if (obs !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, obs, want, cyc);
        end
    endtask

    // Trace recorder: what the DUT did, cycle by cycle, during a logged tile.
    bit logging = 1'b0;
    int cur_len;
    int xq[$], xcyc[$], popq[$], renc[$], rena[$], accc[$], wc[$], wa[$];
    int n_load, n_exec, n_l0wr, n_l0rd, n_done, n_err, n_busy, last_load, done_cyc;
    bit valid_prev, drain_prev, in_drain, exp_pop;

    always @(negedge clk) begin
        if (logging) begin
            // Drain model: a pop follows every DRAIN cycle that saw valid while pops remain.
            in_drain = (cur_len > 0) && (n_exec == cur_len) && (o_inst_w != 2'b10)
                       && !o_done && (n_done == 0);
            exp_pop  = drain_prev && valid_prev && (popq.size() < cur_len);
            check("pop", 64'(o_ofifo_rd), 64'(exp_pop));
            if (!o_xmem_cen) begin xq.push_back(int'(o_xmem_addr)); xcyc.push_back(cyc); end
            if (o_inst_w == 2'b01) begin n_load++; last_load = cyc; end
            if (o_inst_w == 2'b10) n_exec++;
            if (o_l0_wr) n_l0wr++;
            if (o_l0_rd) n_l0rd++;
            if (o_ofifo_rd) popq.push_back(cyc);
            if (o_pmem_ren) begin renc.push_back(cyc); rena.push_back(int'(o_pmem_raddr)); end
            if (o_sfp_acc_en) accc.push_back(cyc);
            if (o_pmem_wen) begin wc.push_back(cyc); wa.push_back(int'(o_pmem_waddr)); end
            if (o_done) begin n_done++; done_cyc = cyc; end
            if (o_err) n_err++;
            if (o_busy) n_busy++;
            drain_prev = in_drain;
            valid_prev = i_ofifo_valid;
        end
    end

    task automatic clear_log(input int len);
        xq.delete(); xcyc.delete(); popq.delete(); renc.delete(); rena.delete();
        accc.delete(); wc.delete(); wa.delete();
        n_load = 0; n_exec = 0; n_l0wr = 0; n_l0rd = 0; n_done = 0; n_err = 0; n_busy = 0;
        last_load = 0; done_cyc = 0; valid_prev = 0; drain_prev = 0; cur_len = len;
    endtask

    // vmode: 0 = valid always high, 1 = pattern 1,0,0,..., 2 = random 75 percent.
    task automatic run_tile(input int w, input int x, input int p, input int len,
                            input bit acc, input int vmode, input bit hold);
        int t;
        bit seen;
        clear_log(len);
        i_w_base = AW'(w); i_x_base = AW'(x); i_p_base = AW'(p);
        i_len = 8'(len); i_acc = acc;
        logging = 1'b1;
        i_start = 1'b1;
        @(posedge clk); #1;
        if (!hold) i_start = 1'b0;
        seen = 1'b0;
        t = 0;
        while (!seen && t < 3000) begin
            i_ofifo_valid = (vmode == 0) ? 1'b1 :
                            (vmode == 1) ? (t % 3 == 0) : ($urandom_range(3) != 0);
            if (hold && o_inst_w == 2'b10) i_start = 1'b0;
            @(posedge clk); #1;
            t++;
            if (n_done > 0) seen = 1'b1;
        end
        check("timeout", 64'(seen), 64'(1));
        i_ofifo_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        logging = 1'b0;

        check("done_cnt", 64'(n_done), 64'(1));
        check("err_cnt", 64'(n_err), 64'(0));
        check("busy_end", 64'(o_busy), 64'(0));
        check("xrd_cnt", 64'(xq.size()), 64'(COL + len));
        for (int i = 0; i < xq.size() && i < COL + len; i++)
            check("xaddr", 64'(xq[i]), 64'(i < COL ? (w + i) & AMASK : (x + i - COL) & AMASK));
        check("load_cyc", 64'(n_load), 64'(COL));
        check("exec_cyc", 64'(n_exec), 64'(len));
        check("l0_wr_cnt", 64'(n_l0wr), 64'(COL + len));
        check("l0_rd_cnt", 64'(n_l0rd), 64'(COL + len));
        if (len > 0 && xcyc.size() > COL)
            check("settle", 64'(xcyc[COL] - last_load - 1), 64'(ROW + COL));
        else if (len == 0)
            check("settle", 64'(done_cyc - last_load - 1), 64'(ROW + COL));
        check("pop_cnt", 64'(popq.size()), 64'(len));
        check("wr_cnt", 64'(wc.size()), 64'(len));
        for (int k = 0; k < wc.size() && k < popq.size(); k++) begin
            check("waddr", 64'(wa[k]), 64'((p + k) & AMASK));
            check("wr_lat", 64'(wc[k] - popq[k]), 64'(LAT + 1));
        end
        check("ren_cnt", 64'(renc.size()), 64'(acc ? len : 0));
        check("acc_cnt", 64'(accc.size()), 64'(acc ? len : 0));
        for (int k = 0; k < renc.size() && k < popq.size() && k < accc.size(); k++) begin
            check("raddr", 64'(rena[k]), 64'((p + k) & AMASK));
            check("ren_cyc", 64'(renc[k]), 64'(popq[k]));
            check("acc_align", 64'(accc[k] - renc[k]), 64'(1));
        end
    endtask

    initial begin
        int found;
        // 1: reset release, idle for 100 cycles
        repeat (3) @(posedge clk);
        #1 check("rst_outs", 64'(outs), 64'(RST_OUTS));
        reset = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            check("idle_outs", 64'(outs), 64'(RST_OUTS));
        end

        // 2, 3: basic tile, then accumulate with a stalling OFIFO
        run_tile('h10, 'h40, 'h80, 4, 1'b0, 0, 1'b0);
        run_tile('h10, 'h40, 'h80, 4, 1'b1, 1, 1'b0);

        // 4: zero-length tile and an oversized rejected start
        run_tile('h10, 'h40, 'h80, 0, 1'b0, 0, 1'b0);
        clear_log(0);
        logging = 1'b1;
        i_len = 8'd65; i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
        check("err_pulse", 64'(o_err), 64'(1));
        repeat (5) @(posedge clk);
        #1 logging = 1'b0;
        check("err_once", 64'(n_err), 64'(1));
        check("err_busy", 64'(n_busy), 64'(0));
        check("err_xrd", 64'(xq.size()), 64'(0));

        // 5: reset during execute aborts the tile, then a fresh tile completes
        i_w_base = 11'h20; i_x_base = 11'h50; i_p_base = 11'h90; i_len = 8'd8; i_acc = 1'b1;
        i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            @(posedge clk); #1;
            if (o_inst_w == 2'b10) found = 1;
        end
        check("reach_exec", 64'(found), 64'(1));
        #2 reset = 1'b0;
        #1 check("abort_outs", 64'(outs), 64'(RST_OUTS));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("abort_done", 64'(o_done), 64'(0));
        end
        reset = 1'b1;
        @(posedge clk); #1;
        run_tile('h20, 'h50, 'h90, 8, 1'b1, 0, 1'b0);

        // 6: PMEM address wrap with i_start held through the tile
        run_tile('h10, 'h40, 'h7FE, 4, 1'b0, 0, 1'b1);

        // Randomized tiles, including the maximum legal length
        run_tile(int'($urandom_range(AMASK)), int'($urandom_range(AMASK)),
                 int'($urandom_range(AMASK)), 64, 1'b1, 2, 1'b0);
        for (int r = 0; r < 6; r++)
            run_tile(int'($urandom_range(AMASK)), int'($urandom_range(AMASK)),
                     int'($urandom_range(AMASK)), int'($urandom_range(64, 1)),
                     1'($urandom_range(1)), 2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
